// File: rtl/alu_issue.sv
// alu_issue: ID/EX stage that decodes RV32I ALU instructions and registers operands/select behind a valid/ready handshake.
// Optional ALU_ISSUE_FWD_EN adds a write-back forwarding path into the rs1/rs2 operand muxes.
module alu_issue #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
`ifdef ALU_ISSUE_FWD_EN
  input  logic            fwd_valid,
  input  logic [4:0]      fwd_rd,
  input  logic [XLEN-1:0] fwd_data,
`endif
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_sel,
  output logic [4:0]      out_rd,
  output logic            out_wb_en,
  output logic            out_illegal
);
  localparam logic [3:0] SEL_ADD = 4'h0;
  logic [6:0] w_opc, w_f7;
  logic [2:0] w_f3;
  logic w_op, w_opi, w_lui, w_auipc, w_legal, w_alt, w_accept;
  logic [XLEN-1:0] w_rs1, w_rs2, w_imm_i, w_imm_u, w_a, w_b;
  logic [3:0] w_sel;
  assign w_opc   = in_instr[6:0];
  assign w_f3    = in_instr[14:12];
  assign w_f7    = in_instr[31:25];
  assign w_op    = w_opc == 7'b0110011;
  assign w_opi   = w_opc == 7'b0010011;
  assign w_lui   = w_opc == 7'b0110111;
  assign w_auipc = w_opc == 7'b0010111;
`ifdef ALU_ISSUE_FWD_EN
  assign w_rs1 = (fwd_valid && fwd_rd != 5'd0 && fwd_rd == in_instr[19:15]) ? fwd_data : rs1_data;
  assign w_rs2 = (fwd_valid && fwd_rd != 5'd0 && fwd_rd == in_instr[24:20]) ? fwd_data : rs2_data;
`else
  assign w_rs1 = rs1_data;
  assign w_rs2 = rs2_data;
`endif
  assign w_imm_i = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  assign w_imm_u = XLEN'({in_instr[31:12], 12'b0});
  // funct7=0100000 selects SUB/SRA; OP-IMM has no SUB so only funct3 101 honours it there
  assign w_alt = w_f7[5] && (w_f3 == 3'b101 || (w_op && w_f3 == 3'b000));
  always_comb begin
    w_legal = w_lui || w_auipc
           || (w_op && (w_f7 == 7'b0 || (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101))))
           || (w_opi && (w_f3 == 3'b001 ? w_f7 == 7'b0 :
                         w_f3 == 3'b101 ? (w_f7 == 7'b0 || w_f7 == 7'b0100000) : 1'b1));
    w_sel = (w_legal && (w_op || w_opi)) ? {w_alt, w_f3} : SEL_ADD;
    w_a   = !w_legal ? '0 : w_lui ? '0 : w_auipc ? in_pc : w_rs1;
    w_b   = !w_legal ? '0 : w_op ? w_rs2 : w_opi ? w_imm_i : w_imm_u;
  end
  assign in_ready = !out_valid || out_ready;
  assign w_accept = in_valid && in_ready && !flush;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_sel     <= SEL_ADD;
      out_rd      <= 5'd0;
      out_wb_en   <= 1'b0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (w_accept) begin
      out_valid   <= 1'b1;
      alu_a       <= w_a;
      alu_b       <= w_b;
      alu_sel     <= w_sel;
      out_rd      <= in_instr[11:7];
      out_wb_en   <= w_legal && in_instr[11:7] != 5'd0;
      out_illegal <= !w_legal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed bench for alu_issue covering reset, decode, handshake, flush and forwarding.
module tb_alu_issue;
  localparam logic [3:0] ADD = 4'h0, SUB = 4'h8, SRA = 4'hD;
  logic clk = 0, rst = 1, in_valid = 0, in_ready, flush = 0, out_valid, out_ready = 1;
  logic [31:0] in_instr = 0, in_pc = 0, rs1_data = 0, rs2_data = 0, alu_a, alu_b;
  logic [3:0] alu_sel;
  logic [4:0] out_rd;
  logic out_wb_en, out_illegal;
  logic fwd_valid = 0;
  logic [4:0] fwd_rd = 0;
  logic [31:0] fwd_data = 0;
  int total = 0, passed = 0;

  always #5 clk = ~clk;

  alu_issue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
`ifdef ALU_ISSUE_FWD_EN
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
`endif
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .alu_a(alu_a), .alu_b(alu_b),
    .alu_sel(alu_sel), .out_rd(out_rd), .out_wb_en(out_wb_en), .out_illegal(out_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] r1, input logic [31:0] r2);
    in_valid = 1; in_instr = ins; in_pc = pc; rs1_data = r1; rs2_data = r2;
    step();
    in_valid = 0;
  endtask

  initial begin
    step();
    rst = 0;
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_sel", 32'(alu_sel), 32'(ADD));
    chk("rst_ready", 32'(in_ready), 1);
    step();
    // sub x3,x1,x2 held under backpressure, then reset asynchronously
    out_ready = 0;
    issue(32'h402081B3, 0, 10, 3);
    chk("sub_valid", 32'(out_valid), 1);
    chk("sub_a", alu_a, 10);
    chk("sub_b", alu_b, 3);
    chk("sub_sel", 32'(alu_sel), 32'(SUB));
    chk("sub_rd", 32'(out_rd), 3);
    chk("sub_wb", 32'(out_wb_en), 1);
    chk("stall_ready", 32'(in_ready), 0);
    #2 rst = 1;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_a", alu_a, 0);
    chk("arst_b", alu_b, 0);
    chk("arst_sel", 32'(alu_sel), 32'(ADD));
    chk("arst_rd", 32'(out_rd), 0);
    chk("arst_wb", 32'(out_wb_en), 0);
    #1 rst = 0;
    out_ready = 1;
    step();
    issue(32'h002081B3, 0, 10, 3);
    chk("add_sel", 32'(alu_sel), 32'(ADD));
    chk("add_a", alu_a, 10);
    step();
    chk("drain_valid", 32'(out_valid), 0);
    chk("drain_hold_a", alu_a, 10);
    issue(32'h40335293, 0, 32'h80000000, 0);
    chk("srai_sel", 32'(alu_sel), 32'(SRA));
    chk("srai_b", alu_b, 32'h00000403);
    chk("srai_a", alu_a, 32'h80000000);
    chk("srai_rd", 32'(out_rd), 5);
    issue(32'hFFF00093, 0, 0, 0);
    chk("addi_b", alu_b, 32'hFFFFFFFF);
    chk("addi_sel", 32'(alu_sel), 32'(ADD));
    issue(32'h123450B7, 0, 32'h55, 32'h66);
    chk("lui_a", alu_a, 0);
    chk("lui_b", alu_b, 32'h12345000);
    issue(32'h00001117, 32'h100, 32'h55, 0);
    chk("auipc_a", alu_a, 32'h100);
    chk("auipc_b", alu_b, 32'h1000);
    chk("auipc_rd", 32'(out_rd), 2);
    issue(32'h40209033, 0, 7, 8);
    chk("ill_f7_illegal", 32'(out_illegal), 1);
    chk("ill_f7_wb", 32'(out_wb_en), 0);
    chk("ill_f7_a", alu_a, 0);
    chk("ill_f7_b", alu_b, 0);
    issue(32'h00012183, 0, 7, 8);
    chk("ill_opc_illegal", 32'(out_illegal), 1);
    chk("ill_opc_rd", 32'(out_rd), 3);
    chk("ill_opc_wb", 32'(out_wb_en), 0);
    issue(32'h00100093, 0, 0, 0);
    chk("legal_again", 32'(out_illegal), 0);
    step();
    // backpressure: three addi x1,x0,N with the consumer stalled two cycles
    out_ready = 0;
    in_valid = 1; in_instr = 32'h00100093; rs1_data = 0;
    step();
    chk("bp1_valid", 32'(out_valid), 1);
    chk("bp1_b", alu_b, 1);
    in_instr = 32'h00200093;
    step();
    chk("bp_stall1_b", alu_b, 1);
    chk("bp_stall1_ready", 32'(in_ready), 0);
    step();
    chk("bp_stall2_b", alu_b, 1);
    chk("bp_stall2_valid", 32'(out_valid), 1);
    out_ready = 1;
    #1;
    chk("bp_ready_comb", 32'(in_ready), 1);
    step();
    chk("bp2_b", alu_b, 2);
    in_instr = 32'h00300093;
    step();
    chk("bp3_b", alu_b, 3);
    chk("bp3_valid", 32'(out_valid), 1);
    in_valid = 0;
    step();
    chk("bp_done_valid", 32'(out_valid), 0);
    // flush drops both the held entry and the incoming one
    out_ready = 0;
    issue(32'h00500093, 0, 0, 0);
    chk("fl_held", 32'(out_valid), 1);
    in_valid = 1; in_instr = 32'h00600093; flush = 1;
    step();
    chk("fl_valid", 32'(out_valid), 0);
    flush = 0; in_valid = 0;
    step();
    chk("fl_dropped", 32'(out_valid), 0);
    chk("fl_hold_b", alu_b, 5);
    out_ready = 1;
`ifdef ALU_ISSUE_FWD_EN
    fwd_valid = 1; fwd_rd = 1; fwd_data = 32'hDEADBEEF;
    issue(32'h002081B3, 0, 5, 6);
    chk("fwd_a", alu_a, 32'hDEADBEEF);
    chk("fwd_b", alu_b, 6);
    fwd_rd = 0;
    issue(32'h002081B3, 0, 5, 6);
    chk("fwd_x0_a", alu_a, 5);
    fwd_rd = 2;
    issue(32'h002081B3, 0, 5, 6);
    chk("fwd_rs2_b", alu_b, 32'hDEADBEEF);
    fwd_valid = 0;
`endif
    step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
